scalar_mult_ladder: RTL
=======================

# scalar_mult_ladder

Parametrised successor to the ECC scalar multiplier: computes R = a·P for a SCALAR_W-bit scalar and a point of two COORD_W-bit coordinates, driving the shared point ALU (add/double) over a single-outstanding-op handshake. Adds a run-time mode select: leading-zero-skipping double-and-add (fast) or Montgomery ladder (constant ALU-op count). Sits between the ECC top-level controller and the point ALU, replacing the fixed 64-bit multiplier.

## Interface
- SCALAR_W, 64, scalar width in bits (≥2)
- COORD_W, 64, coordinate width; POINT_W = 2·COORD_W+1 (x at [COORD_W-1:0], y at [2·COORD_W-1:COORD_W], MSB = infinity flag)
- CNT_W, $clog2(2·SCALAR_W+1), width of op_count

Clock is clk; reset is rst, asynchronous, active-low.
- clk  in  1  clock
- rst  in  1  async active-low reset
- start  in  1  request; sampled only in IDLE
- mode  in  1  0 = double-and-add with leading-zero skip, 1 = Montgomery ladder
- a  in  SCALAR_W  scalar
- P  in  POINT_W  base point
- busy  out  1  high from LOAD through OUT
- done  out  1  one-cycle pulse in OUT
- R  out  POINT_W  result; held until next LOAD
- op_count  out  CNT_W  ALU ops issued for last/current job
- alu_P, alu_Q  out  POINT_W  ALU operands
- alu_op  out  2  00 add, 10 double (01 sub never issued)
- alu_en  out  1  one-cycle issue pulse
- alu_R  in  POINT_W  ALU result
- alu_done  in  1  result valid pulse

## Operation
- States: IDLE, LOAD, SCAN, DBL, ADD, NEXT, OUT.
- IDLE→LOAD on start; start while busy ignored. LOAD captures a, P, mode; idx←SCALAR_W-1; R0←INF ({1,0}); R1←P; op_count←0.
- Mode 0: LOAD→SCAN. SCAN examines a[idx] one bit/cycle: 0 and idx>0 → idx−1, stay; 0 and idx==0 → OUT (R=INF); 1 → R0←P (no ALU op), →NEXT. Then per bit: DBL (R0←2R0); if a[idx]=1, ADD (R0←R0+P); NEXT.
- Mode 1: LOAD→ADD directly, every bit processed, no scan. ADD: R0+R1 → bit=1: R0←sum; bit=0: R1←sum. DBL: bit=1: R1←2R1; bit=0: R0←2R0. Order ADD then DBL; DBL operand is the pre-ADD value of the doubled register (both ops read registers as of bit start: latch operand at ADD entry).
- NEXT: idx==0 → OUT; else idx−1, → DBL (mode 0) or ADD (mode 1).
- OUT: R←R0 (R visible from cycle after OUT; done pulses in OUT with R already valid—R written on OUT entry transition), →IDLE.
- Double: alu_P=alu_Q=operand, alu_op=10. Add: alu_P=R0, alu_Q=P (mode 0) or R1 (mode 1), alu_op=00.
- op_count increments on each alu_en; saturates never (max 2·SCALAR_W fits CNT_W).
- Infinity handling belongs to the ALU; block never inspects the flag.

## Timing
- Reset: state IDLE, busy 0, done 0, alu_en 0, R 0, op_count 0, alu_P/alu_Q 0, alu_op 00; internal registers 0.
- alu_en asserted only in the first cycle of DBL/ADD; operands stable for the whole state.
- alu_done ignored in the alu_en cycle; first alu_done afterwards captures alu_R and exits the state next cycle. ALU latency L ≥1 → each op costs L+1 cycles.
- Start in cycle 0 → LOAD cycle 1 → first working state cycle 2.
- Mode 1: done in cycle 2 + SCALAR_W·(2L+3), independent of a.
- Mode 0, highest set bit m, k ones below m: done in cycle 2 + (SCALAR_W−m) + 1 + m·(L+2) + k·(L+1); a=0: done in cycle 2+SCALAR_W.
- Reset mid-job: immediate IDLE, no done, alu_en low; ALU response after reset ignored.
- start in OUT cycle ignored; may be accepted next cycle (IDLE).

## Structure
- Shared package ecc_pkg: ALU op codes (ADD 00, SUB 01, DBL 10), COORD_W default, POINT_W function, INF point constant, coordinate field slices, mode encodings.
- Single module; no sub-module (scan is one comparator per cycle).

## Test plan
Bench uses a toy ALU (L=3) treating x as integer mod 2^64, add = x sum, double = 2x, INF as zero element; P.x=1 so R.x = a.
- mode 0, a=1 → R.x=1, op_count=0, done at cycle 2+64+1.
- mode 0, a=5 → R.x=5, op_count=3 (DBL, DBL, ADD); a=0 → R=INF, op_count=0, done at cycle 66.
- mode 1, a=5 and a=0xFFFF_FFFF_FFFF_FFFF → R.x=a, op_count=128 both, done at cycle 2+64·9=578 both.
- start pulsed while busy, and again in OUT → ignored, single done, R unchanged by them.
- rst low mid-DBL with alu_done arriving after release → busy/done/alu_en 0, R=0, next job correct.
- SCALAR_W=8, COORD_W=16, random a both modes → R.x=a, op_count within bounds.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared ECC definitions: ALU opcodes, run modes, FSM states
// and point layout helpers for the point ALU datapath.
package ecc_pkg;

  localparam int COORD_W_DEF = 64;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_DBL = 2'b10
  } alu_op_e;

  typedef enum logic {
    MODE_DADD   = 1'b0,
    MODE_LADDER = 1'b1
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_DBL,
    S_ADD,
    S_NEXT,
    S_OUT
  } state_e;

  function automatic int point_w(input int cw);
    return 2 * cw + 1;
  endfunction

  function automatic int x_lsb(input int cw);
    return 0 * cw;
  endfunction

  function automatic int y_lsb(input int cw);
    return cw;
  endfunction

  function automatic int inf_bit(input int cw);
    return 2 * cw;
  endfunction

  localparam logic [2*COORD_W_DEF:0] INF_PT =
    {1'b1, {(2*COORD_W_DEF){1'b0}}};

endpackage

// File: rtl/scalar_mult_ladder.sv
// Scalar multiplier R = a*P over the shared point ALU, with
// leading-zero-skip double-and-add or Montgomery ladder.
module scalar_mult_ladder
  import ecc_pkg::*;
#(
  parameter int SCALAR_W = 64,
  parameter int COORD_W  = COORD_W_DEF,
  localparam int POINT_W = point_w(COORD_W),
  parameter int CNT_W    = $clog2(2*SCALAR_W+1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic [SCALAR_W-1:0] a,
  input  logic [POINT_W-1:0]  P,
  output logic                busy,
  output logic                done,
  output logic [POINT_W-1:0]  R,
  output logic [CNT_W-1:0]    op_count,
  output logic [POINT_W-1:0]  alu_P,
  output logic [POINT_W-1:0]  alu_Q,
  output logic [1:0]          alu_op,
  output logic                alu_en,
  input  logic [POINT_W-1:0]  alu_R,
  input  logic                alu_done
);

  localparam int IDX_W = $clog2(SCALAR_W);
  localparam logic [POINT_W-1:0] INF =
    {1'b1, {(2*COORD_W){1'b0}}};

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  alu_op_e               op_q, op_d;
  logic [SCALAR_W-1:0]   a_q, a_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [POINT_W-1:0]    p_q, p_d;
  logic [POINT_W-1:0]    r0_q, r0_d;
  logic [POINT_W-1:0]    r1_q, r1_d;
  logic [POINT_W-1:0]    r_q, r_d;
  logic [POINT_W-1:0]    ap_q, ap_d;
  logic [POINT_W-1:0]    aq_q, aq_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  en_q, en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ladder;
  logic                  op_ok;

  assign ladder = (mode_q == MODE_LADDER);
  // the cycle that issues the op never completes it
  assign op_ok  = alu_done && !en_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    a_d     = a_q;
    p_d     = p_q;
    idx_d   = idx_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    en_d    = 1'b0;
    op_d    = op_q;
    ap_d    = ap_q;
    aq_d    = aq_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          mode_d  = mode_e'(mode);
          a_d     = a;
          p_d     = P;
          idx_d   = IDX_W'(SCALAR_W-1);
          r0_d    = INF;
          r1_d    = P;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: state_d = ladder ? S_ADD : S_SCAN;
      S_SCAN: begin
        if (a_q[idx_q]) begin
          r0_d    = p_q;
          state_d = S_NEXT;
        end else if (idx_q == '0) begin
          state_d = S_OUT;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      S_DBL: begin
        if (op_ok) begin
          if (ladder && a_q[idx_q]) r1_d = alu_R;
          else r0_d = alu_R;
          if (!ladder && a_q[idx_q]) state_d = S_ADD;
          else state_d = S_NEXT;
        end
      end
      S_ADD: begin
        if (op_ok) begin
          if (!ladder || a_q[idx_q]) r0_d = alu_R;
          else r1_d = alu_R;
          state_d = ladder ? S_DBL : S_NEXT;
        end
      end
      S_NEXT: begin
        if (idx_q == '0) begin
          state_d = S_OUT;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
          state_d = ladder ? S_ADD : S_DBL;
        end
      end
      S_OUT: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_OUT && state_q != S_OUT) begin
      r_d    = r0_d;
      done_d = 1'b1;
    end

    if (state_d == S_DBL && state_q != S_DBL) begin
      en_d = 1'b1;
      op_d = ALU_DBL;
      ap_d = (ladder && a_q[idx_d]) ? r1_d : r0_d;
      aq_d = (ladder && a_q[idx_d]) ? r1_d : r0_d;
    end

    if (state_d == S_ADD && state_q != S_ADD) begin
      en_d = 1'b1;
      op_d = ALU_ADD;
      ap_d = r0_d;
      aq_d = ladder ? r1_d : p_q;
    end

    if (en_d) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_DADD;
      op_q    <= ALU_ADD;
      a_q     <= '0;
      idx_q   <= '0;
      p_q     <= '0;
      r0_q    <= '0;
      r1_q    <= '0;
      r_q     <= '0;
      ap_q    <= '0;
      aq_q    <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      op_q    <= op_d;
      a_q     <= a_d;
      idx_q   <= idx_d;
      p_q     <= p_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      r_q     <= r_d;
      ap_q    <= ap_d;
      aq_q    <= aq_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign R        = r_q;
  assign op_count = cnt_q;
  assign alu_P    = ap_q;
  assign alu_Q    = aq_q;
  assign alu_op   = op_q;
  assign alu_en   = en_q;

endmodule
